dfp_arbiter: RTL and testbench

//  Arbitrates the I-cache and D-cache DFP ports onto the single burst memory (bmem) command channel.

---
 rtl/dfp_arbiter_if.sv | 41 ++++
 rtl/dfp_arbiter.sv | 100 ++++++++++
 tb/tb_dfp_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dfp_arbiter_if.sv
// Cache/deserializer/bmem signal bundle around the DFP arbiter.
// slave = arbiter side, master = caches + deserializer + memory side.
interface dfp_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_read;
  logic [255:0]          icache_rdata;
  logic                  icache_resp;

  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic                  dcache_read;
  logic                  dcache_write;
  logic [255:0]          dcache_wdata;
  logic [255:0]          dcache_rdata;
  logic                  dcache_resp;

  logic                  dfp_write;
  logic [255:0]          dfp_wdata;
  logic [255:0]          dfp_rdata;
  logic                  dfp_resp;

  logic                  bmem_ready;
  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;

  modport slave (
    input  icache_addr, icache_read, dcache_addr, dcache_read, dcache_write,
           dcache_wdata, dfp_rdata, dfp_resp, bmem_ready,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           dfp_write, dfp_wdata, bmem_addr, bmem_read, bmem_write
  );

  modport master (
    output icache_addr, icache_read, dcache_addr, dcache_read, dcache_write,
           dcache_wdata, dfp_rdata, dfp_resp, bmem_ready,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           dfp_write, dfp_wdata, bmem_addr, bmem_read, bmem_write
  );
endinterface

// File: rtl/dfp_arbiter.sv
// Round-robin arbiter of I-cache and D-cache line requests onto one bmem channel.
// One transaction in flight; response routed combinationally to the owning cache.
module dfp_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  dfp_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, WR_WAIT} state_e;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} port_e;

  localparam int CW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b0};

  state_e                state_q, state_d;
  port_e                 last_grant_q, last_grant_d;
  port_e                 owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [255:0]          wdata_q, wdata_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;

  logic ic_pend, dc_pend, grant_dc, rd_done, wr_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_DC;
      owner_q      <= OWN_IC;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat_cnt_d   = beat_cnt_q;

    ic_pend  = bus.icache_read;
    dc_pend  = bus.dcache_read | bus.dcache_write;
    // On contention the port that did not win last time gets the grant.
    grant_dc = dc_pend & (~ic_pend | (last_grant_q == OWN_IC));

    case (state_q)
      IDLE: begin
        if (ic_pend | dc_pend) begin
          owner_d      = grant_dc ? OWN_DC : OWN_IC;
          last_grant_d = grant_dc ? OWN_DC : OWN_IC;
          addr_d       = (grant_dc ? bus.dcache_addr : bus.icache_addr) & LINE_MASK;
          wdata_d      = grant_dc ? bus.dcache_wdata : '0;
          state_d      = (grant_dc && bus.dcache_write) ? WR_BURST : RD_REQ;
        end
      end
      RD_REQ:  if (bus.bmem_ready) state_d = RD_WAIT;
      RD_WAIT: if (bus.dfp_resp)   state_d = IDLE;
      WR_BURST: begin
        if (bus.bmem_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = WR_WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      WR_WAIT: if (bus.dfp_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are forced low while reset is asserted so nothing leaks mid-abort.
    rd_done = (state_q == RD_WAIT) & bus.dfp_resp;
    wr_done = (state_q == WR_WAIT) & bus.dfp_resp;

    bus.icache_resp  = ~rst & rd_done & (owner_q == OWN_IC);
    bus.dcache_resp  = ~rst & ((rd_done & (owner_q == OWN_DC)) | wr_done);
    bus.icache_rdata = rst ? '0 : bus.dfp_rdata;
    bus.dcache_rdata = rst ? '0 : bus.dfp_rdata;
    bus.bmem_read    = ~rst & (state_q == RD_REQ);
    bus.bmem_write   = ~rst & (state_q == WR_BURST);
    bus.dfp_write    = ~rst & (state_q == WR_BURST);
    bus.bmem_addr    = rst ? '0 : addr_q;
    bus.dfp_wdata    = rst ? '0 : wdata_q;
  end

endmodule

// File: tb/tb_dfp_arbiter.sv
// Directed bench for dfp_arbiter: the bench plays caches, deserializer and bmem,
// queuing each expected transaction at request time and checking it when issued.
module tb_dfp_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic        dc;
    logic        wr;
    logic [31:0] addr;
    logic [255:0] data;
  } txn_t;

  txn_t sb[$];

  dfp_arbiter_if bus ();

  dfp_arbiter #(.ADDR_WIDTH(32), .BURST_BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push(input logic dc, input logic wr, input logic [31:0] a, input logic [255:0] d);
    txn_t t;
    t.dc = dc; t.wr = wr; t.addr = a; t.data = d;
    sb.push_back(t);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {bus.bmem_read, bus.bmem_write, bus.dfp_write, bus.icache_resp, bus.dcache_resp}, 5'b0);
  endtask

  // Services whichever transaction the arbiter issues next and compares it with the queue head.
  task automatic serve_one(input int stall_at, input int stall_len, input int resp_delay);
    txn_t t;
    bit   found = 0;
    int   hi = 0, beats = 0, stall_left = stall_len;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk); #1;
      if (bus.bmem_read || bus.bmem_write) found = 1;
    end
    if (!found || sb.size() == 0) begin
      chk("cmd_timeout", {255'b0, found}, 256'd2);
      return;
    end
    t = sb.pop_front();
    chk("cmd_is_write", bus.bmem_write, t.wr);
    chk("bmem_addr", bus.bmem_addr, t.addr & 32'hFFFF_FFE0);
    if (t.wr) begin
      chk("dfp_write", bus.dfp_write, 1'b1);
      chk("dfp_wdata", bus.dfp_wdata, t.data);
      for (int c = 0; c < 40 && bus.bmem_write; c++) begin
        hi++;
        if (bus.bmem_ready) beats++;
        @(negedge clk);
        bus.bmem_ready = !(beats == stall_at && stall_left > 0);
        if (!bus.bmem_ready) stall_left--;
        #1;
      end
      chk("wr_cycles", hi, 4 + stall_len);
      chk("wr_wait_no_early_resp", bus.dcache_resp, 1'b0);
      bus.dfp_resp = 1'b1;
      #1;
      chk("wr_dcache_resp", bus.dcache_resp, 1'b1);
      chk("wr_icache_resp_clear", bus.icache_resp, 1'b0);
    end else begin
      @(negedge clk); #1;
      chk("rd_cmd_one_cycle", bus.bmem_read, 1'b0);
      for (int c = 0; c < resp_delay; c++) begin
        @(negedge clk); #1;
        chk("rd_no_early_resp", {bus.icache_resp, bus.dcache_resp}, 2'b00);
      end
      @(negedge clk);
      bus.dfp_resp  = 1'b1;
      bus.dfp_rdata = t.data;
      #1;
      if (t.dc) begin
        chk("rd_dcache_resp", bus.dcache_resp, 1'b1);
        chk("rd_dcache_rdata", bus.dcache_rdata, t.data);
        chk("rd_icache_resp_clear", bus.icache_resp, 1'b0);
      end else begin
        chk("rd_icache_resp", bus.icache_resp, 1'b1);
        chk("rd_icache_rdata", bus.icache_rdata, t.data);
        chk("rd_dcache_resp_clear", bus.dcache_resp, 1'b0);
      end
    end
    @(negedge clk);
    bus.dfp_resp  = 1'b0;
    bus.dfp_rdata = '0;
    if (t.dc) begin
      bus.dcache_read  = 1'b0;
      bus.dcache_write = 1'b0;
    end else begin
      bus.icache_read = 1'b0;
    end
    #1;
    chk("resp_single_pulse", {bus.icache_resp, bus.dcache_resp}, 2'b00);
  endtask

  initial begin
    logic [255:0] line;
    bit           found;
    rst = 1'b1;
    bus.icache_addr = '0; bus.icache_read = 1'b0;
    bus.dcache_addr = '0; bus.dcache_read = 1'b0; bus.dcache_write = 1'b0; bus.dcache_wdata = '0;
    bus.dfp_rdata = '0; bus.dfp_resp = 1'b0; bus.bmem_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset_ctrl");
    chk("reset_addr", bus.bmem_addr, 32'h0);
    chk("reset_wdata", bus.dfp_wdata, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("idle_ctrl");

    // Stray deserializer response while idle must not reach either cache.
    @(negedge clk);
    bus.dfp_resp = 1'b1;
    #1;
    chk("stray_resp_idle", {bus.icache_resp, bus.dcache_resp}, 2'b00);
    @(negedge clk);
    bus.dfp_resp = 1'b0;

    // I-cache read with an unaligned address.
    bus.icache_addr = 32'h1000_0004;
    bus.icache_read = 1'b1;
    push(1'b0, 1'b0, 32'h1000_0004, rand_line());
    serve_one(-1, 0, 3);

    // D-cache writeback, memory always ready.
    line = rand_line();
    line[31:0] = 32'hDDCC_BBAA;
    bus.dcache_addr  = 32'h2000_0020;
    bus.dcache_wdata = line;
    bus.dcache_write = 1'b1;
    push(1'b1, 1'b1, 32'h2000_0020, line);
    serve_one(-1, 0, 0);

    // Writeback with memory stalling three cycles at beat 2.
    line = rand_line();
    bus.dcache_addr  = 32'h2000_0047;
    bus.dcache_wdata = line;
    bus.dcache_write = 1'b1;
    push(1'b1, 1'b1, 32'h2000_0047, line);
    serve_one(2, 3, 0);

    // D-cache read and write together: the write is taken.
    line = rand_line();
    bus.dcache_addr  = 32'h4000_0100;
    bus.dcache_wdata = line;
    bus.dcache_read  = 1'b1;
    bus.dcache_write = 1'b1;
    push(1'b1, 1'b1, 32'h4000_0100, line);
    serve_one(-1, 0, 0);

    // D-cache read alone.
    bus.dcache_addr = 32'h5000_001F;
    bus.dcache_read = 1'b1;
    push(1'b1, 1'b0, 32'h5000_001F, rand_line());
    serve_one(-1, 0, 1);

    // Simultaneous reads straight out of reset: I first, then D, twice over.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.icache_addr = 32'h6000_0000 + 32'(r * 32'h40);
      bus.dcache_addr = 32'h7000_0000 + 32'(r * 32'h40);
      bus.icache_read = 1'b1;
      bus.dcache_read = 1'b1;
      push(1'b0, 1'b0, bus.icache_addr, rand_line());
      push(1'b1, 1'b0, bus.dcache_addr, rand_line());
      serve_one(-1, 0, 0);
      serve_one(-1, 0, 0);
      @(negedge clk);
    end

    // Reset in the middle of a write burst, after two beats.
    bus.dcache_addr  = 32'h3000_0040;
    bus.dcache_wdata = rand_line();
    bus.dcache_write = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (bus.bmem_write) found = 1;
    end
    chk("abort_burst_started", found, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.dcache_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("abort_ctrl_zero");
    chk("abort_addr_zero", bus.bmem_addr, 32'h0);
    chk("abort_wdata_zero", bus.dfp_wdata, 256'h0);
    bus.dfp_resp = 1'b1;
    #1;
    chk("abort_no_resp", {bus.icache_resp, bus.dcache_resp}, 2'b00);
    @(negedge clk);
    bus.dfp_resp = 1'b0;

    // Fresh write after the abort must run a full four-beat burst.
    line = rand_line();
    bus.dcache_addr  = 32'h3000_0080;
    bus.dcache_wdata = line;
    bus.dcache_write = 1'b1;
    push(1'b1, 1'b1, 32'h3000_0080, line);
    serve_one(-1, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
